// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit with HI/LO result registers.
// Define MDU_MADD_EN to add the MADD/MADDU/MSUB/MSUBU accumulate ops.
module mult_div_unit #(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam logic [3:0] OP_MULT  = 4'd0;
    localparam logic [3:0] OP_MULTU = 4'd1;
    localparam logic [3:0] OP_DIV   = 4'd2;
    localparam logic [3:0] OP_DIVU  = 4'd3;
    localparam logic [3:0] OP_MTHI  = 4'd4;
    localparam logic [3:0] OP_MTLO  = 4'd5;
`ifdef MDU_MADD_EN
    localparam logic [3:0] OP_MADD  = 4'd6;
    localparam logic [3:0] OP_MADDU = 4'd7;
    localparam logic [3:0] OP_MSUB  = 4'd8;
    localparam logic [3:0] OP_MSUBU = 4'd9;
`endif

    localparam logic [5:0] MCNT = 6'(MULT_CYCLES);
    localparam logic [5:0] DCNT = 6'(DIV_CYCLES);

    logic [5:0]         cnt;
    logic [3:0]         op_q;
    logic [WIDTH-1:0]   opa;
    logic [WIDTH-1:0]   opb;

    logic [2*WIDTH-1:0] prod_s;
    logic [2*WIDTH-1:0] prod_u;
    logic [WIDTH-1:0]   amag;
    logic [WIDTH-1:0]   bmag;
    logic [WIDTH-1:0]   qmag;
    logic [WIDTH-1:0]   rmag;
    logic [WIDTH-1:0]   quo_s;
    logic [WIDTH-1:0]   rem_s;
    logic [WIDTH-1:0]   quo_u;
    logic [WIDTH-1:0]   rem_u;
    logic [WIDTH-1:0]   nhi;
    logic [WIDTH-1:0]   nlo;

    assign busy = (cnt != 6'd0);

    // Sign/zero extension to 2*WIDTH makes a plain multiply exact
    assign prod_s = {{WIDTH{opa[WIDTH-1]}}, opa} *
                    {{WIDTH{opb[WIDTH-1]}}, opb};
    assign prod_u = {{WIDTH{1'b0}}, opa} * {{WIDTH{1'b0}}, opb};

    // Signed divide on magnitudes; most-negative / -1 wraps naturally
    assign amag  = opa[WIDTH-1] ? -opa : opa;
    assign bmag  = opb[WIDTH-1] ? -opb : opb;
    assign qmag  = (bmag != '0) ? amag / bmag : '0;
    assign rmag  = (bmag != '0) ? amag % bmag : '0;
    assign quo_s = (opa[WIDTH-1] ^ opb[WIDTH-1]) ? -qmag : qmag;
    assign rem_s = opa[WIDTH-1] ? -rmag : rmag;
    assign quo_u = (opb != '0) ? opa / opb : '0;
    assign rem_u = (opb != '0) ? opa % opb : '0;

    // Result selected for the commit edge; default holds HI/LO
    always_comb begin
        nhi = hi;
        nlo = lo;
        case (op_q)
            OP_MULT:  {nhi, nlo} = prod_s;
            OP_MULTU: {nhi, nlo} = prod_u;
            OP_DIV: begin
                if (opb != '0) begin
                    nhi = rem_s;
                    nlo = quo_s;
                end
            end
            OP_DIVU: begin
                if (opb != '0) begin
                    nhi = rem_u;
                    nlo = quo_u;
                end
            end
`ifdef MDU_MADD_EN
            OP_MADD:  {nhi, nlo} = {hi, lo} + prod_s;
            OP_MADDU: {nhi, nlo} = {hi, lo} + prod_u;
            OP_MSUB:  {nhi, nlo} = {hi, lo} - prod_s;
            OP_MSUBU: {nhi, nlo} = {hi, lo} - prod_u;
`endif
            default: begin
                nhi = hi;
                nlo = lo;
            end
        endcase
    end

    // Accept, count down and commit; busy drops requests
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt  <= 6'd0;
            op_q <= 4'd0;
            opa  <= '0;
            opb  <= '0;
            hi   <= '0;
            lo   <= '0;
        end else if (cnt != 6'd0) begin
            cnt <= cnt - 6'd1;
            if (cnt == 6'd1) begin
                hi <= nhi;
                lo <= nlo;
            end
        end else if (start) begin
            case (op)
                OP_MULT, OP_MULTU: begin
                    cnt  <= MCNT;
                    op_q <= op;
                    opa  <= a;
                    opb  <= b;
                end
`ifdef MDU_MADD_EN
                OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: begin
                    cnt  <= MCNT;
                    op_q <= op;
                    opa  <= a;
                    opb  <= b;
                end
`endif
                OP_DIV, OP_DIVU: begin
                    cnt  <= DCNT;
                    op_q <= op;
                    opa  <= a;
                    opb  <= b;
                end
                OP_MTHI: hi <= a;
                OP_MTLO: lo <= a;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit with a 64-bit arithmetic model.
// Works with or without MDU_MADD_EN defined.
module tb_mult_div_unit;

    logic        clk;
    logic        reset;
    logic        start;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    int          total;
    int          bad;
    logic [63:0] m;

    mult_div_unit #(
        .WIDTH(32),
        .MULT_CYCLES(5),
        .DIV_CYCLES(10)
    ) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .op(op),
        .a(a),
        .b(b),
        .busy(busy),
        .hi(hi),
        .lo(lo)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic int lat(input logic [3:0] o);
        case (o)
            4'd0, 4'd1: return 5;
            4'd2, 4'd3: return 10;
`ifdef MDU_MADD_EN
            4'd6, 4'd7, 4'd8, 4'd9: return 5;
`endif
            default: return 0;
        endcase
    endfunction

    function automatic logic [63:0] ref_op(input logic [3:0] o,
                                           input logic [31:0] x,
                                           input logic [31:0] y,
                                           input logic [63:0] cur);
        longint      sx;
        longint      sy;
        longint      q;
        longint      r;
        logic [63:0] ps;
        logic [63:0] pu;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ps = 64'(sx * sy);
        pu = 64'(x) * 64'(y);
        ref_op = cur;
        case (o)
            4'd0: ref_op = ps;
            4'd1: ref_op = pu;
            4'd2: begin
                if (y != 0) begin
                    q = sx / sy;
                    r = sx % sy;
                    ref_op = {r[31:0], q[31:0]};
                end
            end
            4'd3: if (y != 0) ref_op = {x % y, x / y};
            4'd4: ref_op = {x, cur[31:0]};
            4'd5: ref_op = {cur[63:32], x};
`ifdef MDU_MADD_EN
            4'd6: ref_op = cur + ps;
            4'd7: ref_op = cur + pu;
            4'd8: ref_op = cur - ps;
            4'd9: ref_op = cur - pu;
`endif
            default: ref_op = cur;
        endcase
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    // Issue one op, scramble operands, wait (bounded) for busy to drop
    task automatic run_op(input logic [3:0] o, input logic [31:0] x,
                          input logic [31:0] y, output int cyc,
                          output bit held);
        logic [31:0] h0;
        logic [31:0] l0;
        h0 = hi;
        l0 = lo;
        held = 1'b1;
        start = 1'b1;
        op = o;
        a = x;
        b = y;
        @(posedge clk); #1;
        start = 1'b0;
        a = $urandom;
        b = $urandom;
        cyc = 0;
        while (busy && cyc < 200) begin
            if (hi !== h0 || lo !== l0) held = 1'b0;
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b1;
        op = 4'd4;
        a = 32'hDEAD_BEEF;
        b = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_busy got=%b exp=0", busy);
        end
        total++;
        if (hi !== 32'h0 || lo !== 32'h0) begin
            bad++;
            $display("FAIL reset_hilo got=%h_%h exp=0_0", hi, lo);
        end
        reset = 1'b0;
        start = 1'b0;
        m = 64'h0;
        @(posedge clk); #1;
        total++;
        if ({hi, lo} !== m || busy !== 1'b0) begin
            bad++;
            $display("FAIL post_reset got=%h busy=%b exp=%h", {hi, lo}, busy, m);
        end
    endtask

    task automatic test_mult();
        int cyc;
        bit held;
        m = ref_op(4'd0, 32'hFFFF_FFFD, 32'd7, m);
        run_op(4'd0, 32'hFFFF_FFFD, 32'd7, cyc, held);
        total++;
        if (cyc !== 5) begin
            bad++;
            $display("FAIL mult_latency got=%0d exp=5", cyc);
        end
        total++;
        if (held !== 1'b1) begin
            bad++;
            $display("FAIL mult_hold got=%b exp=1", held);
        end
        total++;
        if ({hi, lo} !== 64'hFFFF_FFFF_FFFF_FFEB || {hi, lo} !== m) begin
            bad++;
            $display("FAIL mult_value got=%h exp=%h", {hi, lo}, m);
        end
    endtask

    task automatic test_div();
        int cyc;
        bit held;
        m = ref_op(4'd2, 32'hFFFF_FFF9, 32'd2, m);
        run_op(4'd2, 32'hFFFF_FFF9, 32'd2, cyc, held);
        total++;
        if (cyc !== 10 || held !== 1'b1) begin
            bad++;
            $display("FAIL div_latency got=%0d held=%b exp=10", cyc, held);
        end
        total++;
        if ({hi, lo} !== 64'hFFFF_FFFF_FFFF_FFFD || {hi, lo} !== m) begin
            bad++;
            $display("FAIL div_value got=%h exp=%h", {hi, lo}, m);
        end
        run_op(4'd3, 32'd7, 32'd0, cyc, held);
        total++;
        if (cyc !== 10) begin
            bad++;
            $display("FAIL divz_latency got=%0d exp=10", cyc);
        end
        total++;
        if ({hi, lo} !== m) begin
            bad++;
            $display("FAIL divz_keep got=%h exp=%h", {hi, lo}, m);
        end
        m = ref_op(4'd2, 32'h8000_0000, 32'hFFFF_FFFF, m);
        run_op(4'd2, 32'h8000_0000, 32'hFFFF_FFFF, cyc, held);
        total++;
        if ({hi, lo} !== 64'h0000_0000_8000_0000 || {hi, lo} !== m) begin
            bad++;
            $display("FAIL div_ovf got=%h exp=%h", {hi, lo}, m);
        end
    endtask

    task automatic test_multu_drop();
        int cyc;
        m = ref_op(4'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, m);
        start = 1'b1;
        op = 4'd1;
        a = 32'hFFFF_FFFF;
        b = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        start = 1'b0;
        a = 32'd3;
        @(posedge clk); #1;
        start = 1'b1;
        op = 4'd0;
        a = 32'd5;
        b = 32'd9;
        @(posedge clk); #1;
        start = 1'b0;
        a = $urandom;
        b = $urandom;
        cyc = 2;
        while (busy && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
        end
        total++;
        if (cyc !== 5) begin
            bad++;
            $display("FAIL drop_latency got=%0d exp=5", cyc);
        end
        total++;
        if ({hi, lo} !== 64'hFFFF_FFFE_0000_0001 || {hi, lo} !== m) begin
            bad++;
            $display("FAIL multu_value got=%h exp=%h", {hi, lo}, m);
        end
        repeat (12) @(posedge clk);
        #1;
        total++;
        if ({hi, lo} !== m || busy !== 1'b0) begin
            bad++;
            $display("FAIL drop_nocommit got=%h busy=%b exp=%h", {hi, lo}, busy, m);
        end
    endtask

    task automatic test_mt();
        int cyc;
        logic [31:0] x;
        logic [31:0] y;
        x = $urandom;
        y = $urandom;
        m = ref_op(4'd0, x, y, m);
        start = 1'b1;
        op = 4'd0;
        a = x;
        b = y;
        @(posedge clk); #1;
        op = 4'd5;
        a = 32'h1234;
        @(posedge clk); #1;
        op = 4'd4;
        a = 32'h5678;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 2;
        while (busy && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
        end
        total++;
        if (cyc !== 5 || {hi, lo} !== m) begin
            bad++;
            $display("FAIL mt_busy_ignored got=%h cyc=%0d exp=%h", {hi, lo}, cyc, m);
        end
        start = 1'b1;
        op = 4'd5;
        a = 32'h1234;
        @(posedge clk); #1;
        start = 1'b0;
        m = ref_op(4'd5, 32'h1234, 32'h0, m);
        total++;
        if ({hi, lo} !== m || lo !== 32'h1234 || busy !== 1'b0) begin
            bad++;
            $display("FAIL mtlo_idle got=%h busy=%b exp=%h", {hi, lo}, busy, m);
        end
        start = 1'b1;
        op = 4'd4;
        a = 32'hCAFE_0001;
        @(posedge clk); #1;
        start = 1'b0;
        m = ref_op(4'd4, 32'hCAFE_0001, 32'h0, m);
        total++;
        if ({hi, lo} !== m || busy !== 1'b0) begin
            bad++;
            $display("FAIL mthi_idle got=%h busy=%b exp=%h", {hi, lo}, busy, m);
        end
    endtask

    task automatic test_reset_abort();
        int cyc;
        bit held;
        run_op(4'd4, 32'h1111_2222, 32'h0, cyc, held);
        run_op(4'd5, 32'h3333_4444, 32'h0, cyc, held);
        start = 1'b1;
        op = 4'd2;
        a = 32'd100;
        b = 32'd7;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        start = 1'b1;
        op = 4'd5;
        a = 32'hFFFF;
        @(posedge clk); #1;
        reset = 1'b0;
        start = 1'b0;
        m = 64'h0;
        total++;
        if (busy !== 1'b0 || {hi, lo} !== m) begin
            bad++;
            $display("FAIL abort_reset got=%h busy=%b exp=0", {hi, lo}, busy);
        end
        repeat (15) @(posedge clk);
        #1;
        total++;
        if (busy !== 1'b0 || {hi, lo} !== m) begin
            bad++;
            $display("FAIL abort_nocommit got=%h busy=%b exp=0", {hi, lo}, busy);
        end
    endtask

    task automatic test_madd();
        int cyc;
        bit held;
        logic [31:0] exp_lo;
`ifdef MDU_MADD_EN
        exp_lo = 32'd16;
`else
        exp_lo = 32'd10;
`endif
        run_op(4'd4, 32'd0, 32'd0, cyc, held);
        run_op(4'd5, 32'd10, 32'd0, cyc, held);
        m = {32'd0, 32'd10};
        m = ref_op(4'd6, 32'd2, 32'd3, m);
        run_op(4'd6, 32'd2, 32'd3, cyc, held);
        total++;
        if (cyc !== lat(4'd6)) begin
            bad++;
            $display("FAIL madd_latency got=%0d exp=%0d", cyc, lat(4'd6));
        end
        total++;
        if (lo !== exp_lo || hi !== 32'd0 || {hi, lo} !== m) begin
            bad++;
            $display("FAIL madd_value got=%h exp=%h", {hi, lo}, m);
        end
    endtask

    task automatic test_reserved();
        int cyc;
        bit held;
        for (int o = 10; o < 16; o++) begin
            run_op(4'(o), $urandom, $urandom, cyc, held);
            total++;
            if (cyc !== 0 || busy !== 1'b0 || {hi, lo} !== m) begin
                bad++;
                $display("FAIL reserved_%0d got=%h cyc=%0d exp=%h", o, {hi, lo}, cyc, m);
            end
        end
    endtask

    task automatic test_random();
        int cyc;
        bit held;
        logic [3:0] o;
        logic [31:0] x;
        logic [31:0] y;
        for (int i = 0; i < 150; i++) begin
            o = 4'($urandom_range(0, 15));
            x = pick();
            y = pick();
            m = ref_op(o, x, y, m);
            run_op(o, x, y, cyc, held);
            total++;
            if (cyc !== lat(o) || held !== 1'b1) begin
                bad++;
                $display("FAIL rand_timing i=%0d op=%0d got=%0d held=%b exp=%0d",
                         i, o, cyc, held, lat(o));
            end
            total++;
            if ({hi, lo} !== m) begin
                bad++;
                $display("FAIL rand_value i=%0d op=%0d a=%h b=%h got=%h exp=%h",
                         i, o, x, y, {hi, lo}, m);
            end
        end
    endtask

    initial begin
        total = 0;
        bad = 0;
        reset = 1'b1;
        start = 1'b0;
        op = 4'd0;
        a = 32'h0;
        b = 32'h0;
        m = 64'h0;
        test_reset();
        test_mult();
        test_div();
        test_multu_drop();
        test_mt();
        test_reset_abort();
        test_madd();
        test_reserved();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
